// File: rtl/cg_pkg.sv
// cg_pkg -- shared definitions for the CG iteration sequencer.
//   stage_e : 3-bit stage encoding; each value is also the bit index into
//             stage_start / stage_done.
//   state_e : sequencer FSM states.
//   CG_DEFAULT_TOLERANCE : default convergence threshold (IEEE-754 single).
//   stage_onehot / stage_next : helpers for start-pulse decode and stage order.
package cg_pkg;

    typedef enum logic [2:0] {
        STG_RR    = 3'd0,
        STG_AP    = 3'd1,
        STG_PAP   = 3'd2,
        STG_ALPHA = 3'd3,
        STG_UPDX  = 3'd4,
        STG_RNEW  = 3'd5,
        STG_BETA  = 3'd6,
        STG_UPDP  = 3'd7
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH,
        ST_ERROR
    } state_e;

    localparam logic [31:0] CG_DEFAULT_TOLERANCE = 32'h283424DC;

    function automatic logic [7:0] stage_onehot(input stage_e s);
        logic [7:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic stage_e stage_next(input stage_e s);
        return stage_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog -- per-stage watchdog for the CG sequencer.
//   clk, reset : clock and asynchronous active-low reset.
//   clr        : zero the counter (issued when a stage is started).
//   en         : count while the sequencer is waiting for a stage done.
//   limit_hit  : high on the waiting cycle that completes 'limit' cycles of
//                waiting, so the sequencer can leave on that same edge.
// The counter is $clog2(limit)+1 bits wide and saturates.
module stage_watchdog #(
    parameter int unsigned limit = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic limit_hit
);

    localparam int unsigned CW = $clog2(limit) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed waiting cycles; the current cycle is the next one.
    always_comb begin
        limit_hit = en && ((32'(count) + 32'd1) >= limit);
    end

endmodule

// File: rtl/cg_iteration_sequencer.sv
// cg_iteration_sequencer -- stage sequencer for a conjugate-gradient solver.
//   clk, reset  : clock, asynchronous active-low reset.
//   go          : start a solve (accepted only in IDLE, abort low).
//   abort       : cancel the current solve, no solve_done.
//   stage_done  : per-stage finish pulses (bit = stage_e value).
//   upd_r_done  : r-update finish pulse, paired with UPDX.
//   rsnew       : r.r result from RNEW, compared against tolerance.
//   stage_start : one-hot, single-cycle stage start pulses.
//   rsold_load  : rold <= rsnew command, same cycle as RNEW done is taken.
//   busy        : high from go acceptance until back in IDLE.
//   converged   : solve ended with rsnew <= tolerance.
//   timeout_err : sticky watchdog error for the last solve.
//   iter_count  : completed iterations (saturating).
//   solve_done  : single-cycle pulse when a solve ends (not on abort/reset).
module cg_iteration_sequencer
    import cg_pkg::*;
#(
    parameter int unsigned                 element_width  = 32,
    parameter int unsigned                 max_iterations = 64,
    parameter logic [element_width-1:0]    tolerance      = element_width'(CG_DEFAULT_TOLERANCE),
    parameter int unsigned                 timeout_cycles = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     abort,
    input  logic [7:0]               stage_done,
    input  logic                     upd_r_done,
    input  logic [element_width-1:0] rsnew,
    output logic [7:0]               stage_start,
    output logic                     rsold_load,
    output logic                     busy,
    output logic                     converged,
    output logic                     timeout_err,
    output logic [15:0]              iter_count,
    output logic                     solve_done
);

    state_e      state;
    stage_e      stage;
    logic        updx_seen;
    logic        updr_seen;
    logic        updx_d;
    logic        updr_d;
    logic        stage_ok;
    logic [15:0] next_iter;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_hit;

    stage_watchdog #(
        .limit(timeout_cycles)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr      (wd_clr),
        .en       (wd_en),
        .limit_hit(wd_hit)
    );

    always_comb begin
        wd_clr = (state == ST_ISSUE);
        wd_en  = (state == ST_WAIT);
    end

    // UPDX needs both finish pulses; each is remembered until the other arrives.
    always_comb begin
        updx_d = updx_seen | stage_done[STG_UPDX];
        updr_d = updr_seen | upd_r_done;
        if (stage == STG_UPDX) begin
            stage_ok = updx_d & updr_d;
        end else begin
            stage_ok = stage_done[stage];
        end
        next_iter = (iter_count == 16'hFFFF) ? iter_count : iter_count + 16'd1;
    end

    // Combinational so the load lands in the same cycle the RNEW done is taken.
    always_comb begin
        rsold_load = (state == ST_WAIT) && (stage == STG_RNEW) &&
                     stage_done[STG_RNEW] && !abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            stage       <= STG_RR;
            stage_start <= '0;
            busy        <= 1'b0;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
            iter_count  <= '0;
            solve_done  <= 1'b0;
            updx_seen   <= 1'b0;
            updr_seen   <= 1'b0;
        end else begin
            stage_start <= '0;
            solve_done  <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                stage     <= STG_RR;
                busy      <= 1'b0;
                updx_seen <= 1'b0;
                updr_seen <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go && !abort) begin
                            converged   <= 1'b0;
                            timeout_err <= 1'b0;
                            iter_count  <= '0;
                            stage       <= STG_RR;
                            stage_start <= stage_onehot(STG_RR);
                            busy        <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end

                    // stage_start is registered on entry, so ISSUE lasts one cycle.
                    ST_ISSUE: begin
                        state <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        if (stage_ok) begin
                            updx_seen <= 1'b0;
                            updr_seen <= 1'b0;
                            case (stage)
                                STG_RNEW: begin
                                    if (rsnew <= tolerance) begin
                                        converged  <= 1'b1;
                                        solve_done <= 1'b1;
                                        state      <= ST_FINISH;
                                    end else begin
                                        stage       <= STG_BETA;
                                        stage_start <= stage_onehot(STG_BETA);
                                        state       <= ST_ISSUE;
                                    end
                                end
                                STG_UPDP: begin
                                    iter_count <= next_iter;
                                    if (32'(next_iter) == max_iterations) begin
                                        converged  <= 1'b0;
                                        solve_done <= 1'b1;
                                        state      <= ST_FINISH;
                                    end else begin
                                        // RR belongs to the first iteration only.
                                        stage       <= STG_AP;
                                        stage_start <= stage_onehot(STG_AP);
                                        state       <= ST_ISSUE;
                                    end
                                end
                                default: begin
                                    stage       <= stage_next(stage);
                                    stage_start <= stage_onehot(stage_next(stage));
                                    state       <= ST_ISSUE;
                                end
                            endcase
                        end else if (wd_hit) begin
                            timeout_err <= 1'b1;
                            solve_done  <= 1'b1;
                            updx_seen   <= 1'b0;
                            updr_seen   <= 1'b0;
                            state       <= ST_ERROR;
                        end else if (stage == STG_UPDX) begin
                            updx_seen <= updx_d;
                            updr_seen <= updr_d;
                        end
                    end

                    ST_FINISH, ST_ERROR: begin
                        busy  <= 1'b0;
                        stage <= STG_RR;
                        state <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        stage <= STG_RR;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
